aes_inv_key_sched: RTL and testbench



---
 rtl/aes_inv_key_sched.sv | 129 ++++++++++++
 tb/tb_aes_inv_key_sched.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_sched.sv
// rtl/aes_inv_key_sched.sv - iterative AES-128 inverse key schedule, emits round keys 10 down to 0
module aes_inv_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic         key_valid,
  output logic [3:0]   round_idx,
  output logic         last,
  output logic         busy
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [0:255][7:0] sbox_tbl = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    sub_rot_word = {sbox_tbl[w[23:16]], sbox_tbl[w[15:8]],
                    sbox_tbl[w[7:0]],   sbox_tbl[w[31:24]]};
  endfunction

  // Reverse-order constants; anything outside 1..10 collapses to zero.
  function automatic logic [7:0] rcon_r(input logic [3:0] n);
    case (n)
      4'd1:    rcon_r = 8'h36;
      4'd2:    rcon_r = 8'h1b;
      4'd3:    rcon_r = 8'h80;
      4'd4:    rcon_r = 8'h40;
      4'd5:    rcon_r = 8'h20;
      4'd6:    rcon_r = 8'h10;
      4'd7:    rcon_r = 8'h08;
      4'd8:    rcon_r = 8'h04;
      4'd9:    rcon_r = 8'h02;
      4'd10:   rcon_r = 8'h01;
      default: rcon_r = 8'h00;
    endcase
  endfunction

  state_t       state, state_nxt;
  logic [3:0]   step, step_nxt;
  logic [3:0]   idx_nxt;
  logic [127:0] key_nxt;
  logic         valid_nxt;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  v0, v1, v2, v3;
  logic [127:0] prev_key;

  assign w0 = key_out[127:96];
  assign w1 = key_out[95:64];
  assign w2 = key_out[63:32];
  assign w3 = key_out[31:0];

  assign v3 = w3 ^ w2;
  assign v2 = w2 ^ w1;
  assign v1 = w1 ^ w0;
  assign v0 = w0 ^ sub_rot_word(v3) ^ {rcon_r(step + 4'd1), 24'h0};
  assign prev_key = {v0, v1, v2, v3};

  assign busy = (state != IDLE);
  assign last = key_valid & (round_idx == 4'd0);

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    idx_nxt   = round_idx;
    key_nxt   = key_out;
    valid_nxt = key_valid;
    case (state)
      IDLE: begin
        if (start) begin
          key_nxt   = key_in;
          idx_nxt   = 4'd10;
          step_nxt  = 4'd0;
          valid_nxt = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (key_valid && key_ready) begin
          if (round_idx != 4'd0) begin
            step_nxt = step + 4'd1;
            key_nxt  = prev_key;
            idx_nxt  = round_idx - 4'd1;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= 4'd0;
      round_idx <= 4'd0;
      key_out   <= 128'h0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      step      <= step_nxt;
      round_idx <= idx_nxt;
      key_out   <= key_nxt;
      key_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb/tb_aes_inv_key_sched.sv - directed checks of the inverse key schedule against a forward expansion model
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst, start, key_ready;
  logic [127:0] key_in;
  logic [127:0] key_out;
  logic         key_valid, last, busy;
  logic [3:0]   round_idx;

  int tests = 0;
  int fails = 0;
  logic [7:0]   sb [256];
  logic [127:0] rk [0:10];
  bit           a1;

  aes_inv_key_sched dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .key_ready(key_ready),
    .key_out(key_out), .key_valid(key_valid), .round_idx(round_idx), .last(last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box derived from GF(2^8) inversion plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // mode: 0 ready high, 1 random ready, 2 stall at round 7, 3 restart at round 5,
  //       4 reset at round 4, 5 start held through the final handshake
  task automatic run_seq(input int mode);
    int idx = 10;
    int hs_cnt = 0;
    int stall = 0;
    key_in = rk[10];
    start = 1'b1;
    key_ready = 1'b1;
    tick();
    start = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    for (int cyc = 0; cyc < 200 && hs_cnt < 11; cyc++) begin
      check("valid", key_valid, 1);
      check("busy", busy, 1);
      check("round_idx", round_idx, idx);
      check("key_out", key_out, rk[idx]);
      check("last", last, idx == 0);
      if (a1 && idx == 9) check("a1_r9", key_out, 128'hac7766f319fadc2128d12941575c006e);
      if (a1 && idx == 0) check("a1_r0", key_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      if (mode == 4 && idx == 4) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid", key_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_key", key_out, 0);
        check("rst_idx", round_idx, 0);
        tick();
        check("rst_quiet", key_valid, 0);
        return;
      end
      start = (mode == 3 && idx == 5) || (mode == 5 && idx == 0);
      if (mode == 3 && idx == 5) key_in = {$urandom, $urandom, $urandom, $urandom};
      case (mode)
        1: key_ready = 1'($urandom_range(0, 1));
        2: begin
          if (idx == 7 && stall < 3) begin
            key_ready = 1'b0;
            stall++;
          end else begin
            key_ready = 1'b1;
          end
        end
        default: key_ready = 1'b1;
      endcase
      if (key_ready) begin
        idx--;
        hs_cnt++;
      end
      tick();
    end
    start = 1'b0;
    check("handshakes", hs_cnt, 11);
    check("end_valid", key_valid, 0);
    check("end_busy", busy, 0);
    check("end_last", last, 0);
    if (mode == 2) check("stall_cycles", stall, 3);
  endtask

  initial begin
    build_sbox();
    rst = 1'b1;
    start = 1'b0;
    key_ready = 1'b0;
    key_in = 128'h0;
    a1 = 1'b0;
    tick();
    tick();
    check("reset_key", key_out, 0);
    check("reset_valid", key_valid, 0);
    check("reset_idx", round_idx, 0);
    check("reset_last", last, 0);
    check("reset_busy", busy, 0);

    start = 1'b1;
    key_in = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    tick();
    check("rst_beats_start", key_valid, 0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    check("idle_valid", key_valid, 0);

    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("a1_model", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    a1 = 1'b1;
    run_seq(0);
    run_seq(2);
    run_seq(3);
    run_seq(4);
    run_seq(0);
    run_seq(5);
    tick();
    check("held_start_ignored", key_valid, 0);
    run_seq(0);
    a1 = 1'b0;

    for (int k = 0; k < 20; k++) begin
      expand({$urandom, $urandom, $urandom, $urandom});
      run_seq(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
